// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Booth recoding of {Q0, Q(-1)}
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, Q(-1)}.
module booth_step
    import booth_pkg::*;
#(
    parameter int AW = 10,
    parameter int QW = 9
) (
    input  logic [AW-1:0] a,
    input  logic [QW-1:0] q,
    input  logic          q_m1,
    input  logic [AW-1:0] m,
    output logic [AW-1:0] a_next,
    output logic [QW-1:0] q_next,
    output logic          q_m1_next
);

    logic [AW-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            PAIR_ADD: sum = a + m;
            PAIR_SUB: sum = a - m;
            default:  sum = a;
        endcase
    end

    assign a_next    = {sum[AW-1], sum[AW-1:1]};
    assign q_next    = {sum[0], q[QW-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands,
// one product bit retired per RUN cycle.
module seq_booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Operands are extended by one bit; A adds one guard bit on top.
    localparam int QW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 2);

    state_t state;
    state_t state_next;

    logic [AW-1:0] a;
    logic [QW-1:0] q;
    logic          q_m1;
    logic [AW-1:0] m;
    logic          sgn;
    logic [CW-1:0] count;

    logic [AW-1:0] a_next;
    logic [QW-1:0] q_next;
    logic          q_m1_next;

    logic          accept;
    logic          last;
    logic [CW-1:0] iter;
    logic [AW-1:0] m_load;
    logic [QW-1:0] q_load;
    logic [2*WIDTH-1:0] result;

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .a         (a),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign iter = is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);

    assign m_load = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                              : {2'b00, multiplicand};
    assign q_load = is_signed ? {multiplier[WIDTH-1], multiplier}
                              : {1'b0, multiplier};

    // Signed runs one step fewer, leaving the product one bit higher in {A,Q}.
    assign result = sgn ? {a_next[WIDTH-1:0], q_next[WIDTH:1]}
                        : {a_next[WIDTH-2:0], q_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            sgn     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            a     <= '0;
            q     <= q_load;
            q_m1  <= 1'b0;
            m     <= m_load;
            sgn   <= is_signed;
            count <= iter;
        end else if (state == RUN) begin
            a     <= a_next;
            q     <= q_next;
            q_m1  <= q_m1_next;
            count <= count - CW'(1);
            if (last) begin
                product <= result;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier at WIDTH=8.
module tb_seq_booth_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   multiplicand;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] sb[$];

    seq_booth_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_signed    (is_signed),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [W-1:0] SQ [8] = '{8'h07, 8'hF9, 8'hF9, 8'h07,
                                        8'h80, 8'hFF, 8'h00, 8'h80};
    localparam logic [W-1:0] SM [8] = '{8'h05, 8'hFB, 8'h05, 8'hFB,
                                        8'h80, 8'h07, 8'h07, 8'h7F};
    localparam logic [2*W-1:0] SP [8] = '{16'h0023, 16'h0023, 16'hFFDD,
                                          16'hFFDD, 16'h4000, 16'hFFF9,
                                          16'h0000, 16'hC080};
    localparam logic [W-1:0] UQ [4] = '{8'hFF, 8'h80, 8'h00, 8'hFF};
    localparam logic [W-1:0] UM [4] = '{8'hFF, 8'h02, 8'hFF, 8'h01};
    localparam logic [2*W-1:0] UP [4] = '{16'hFE01, 16'h0100,
                                          16'h0000, 16'h00FF};

    function automatic logic [2*W-1:0] model(bit s, logic [W-1:0] qv,
                                             logic [W-1:0] mv);
        longint x;
        longint y;
        longint p;
        if (s) begin
            x = longint'($signed(qv));
            y = longint'($signed(mv));
        end else begin
            x = longint'({56'd0, qv});
            y = longint'({56'd0, mv});
        end
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Drives one start pulse; returns just after the acceptance edge.
    task automatic issue(bit s, logic [W-1:0] qv, logic [W-1:0] mv,
                         logic [2*W-1:0] exp);
        is_signed    = s;
        multiplier   = qv;
        multiplicand = mv;
        start        = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n,
                             output bit ok);
        lat    = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        n_checks++;
        if (product !== '0) begin
            n_fail++;
            $display("FAIL reset_product: got %h expected 0000", product);
        end
        start      = 1'b1;
        multiplier = 8'h03;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: busy %b expected 0", busy);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(string name, bit s, logic [W-1:0] qv,
                           logic [W-1:0] mv, logic [2*W-1:0] exp);
        int lat;
        int bn;
        bit ok;
        int iter;
        logic [2*W-1:0] e;
        iter = s ? W : W + 1;
        issue(s, qv, mv, exp);
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
            return;
        end
        if (product !== e) begin
            n_fail++;
            $display("FAIL %s_product %h*%h: got %h expected %h",
                     name, qv, mv, product, e);
        end
        n_checks++;
        if (lat != iter) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, iter);
        end
        n_checks++;
        if (bn != iter) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d",
                     name, bn, iter);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || product !== e) begin
            n_fail++;
            $display("FAIL %s_hold: done %b product %h expected 0 %h",
                     name, done, product, e);
        end
    endtask

    task automatic test_signed;
        logic [W-1:0] qv;
        logic [W-1:0] mv;
        for (int i = 0; i < 8; i++) begin
            run_one("signed", 1'b1, SQ[i], SM[i], SP[i]);
        end
        for (int i = 0; i < 6; i++) begin
            qv = W'($urandom_range(0, 255));
            mv = W'($urandom_range(0, 255));
            run_one("signed_rand", 1'b1, qv, mv, model(1'b1, qv, mv));
        end
    endtask

    task automatic test_unsigned;
        logic [W-1:0] qv;
        logic [W-1:0] mv;
        for (int i = 0; i < 4; i++) begin
            run_one("unsigned", 1'b0, UQ[i], UM[i], UP[i]);
        end
        for (int i = 0; i < 6; i++) begin
            qv = W'($urandom_range(0, 255));
            mv = W'($urandom_range(0, 255));
            run_one("unsigned_rand", 1'b0, qv, mv, model(1'b0, qv, mv));
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        int bn;
        bit ok;
        logic [2*W-1:0] e;
        issue(1'b1, 8'h07, 8'h05, 16'h0023);
        repeat (2) @(posedge clk);
        #1;
        is_signed    = 1'b0;
        multiplier   = 8'h33;
        multiplicand = 8'h44;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_timeout: no done within 40 cycles");
            return;
        end
        if (product !== e) begin
            n_fail++;
            $display("FAIL ignore_product: got %h expected %h", product, e);
        end
        n_checks++;
        if (lat + 3 != W) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected %0d",
                     lat + 3, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        bit seen;
        issue(1'b1, 8'd100, 8'hFD, model(1'b1, 8'd100, 8'hFD));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        n_checks++;
        if (busy !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL abort_state: busy %b product %h expected 0 0000",
                     busy, product);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_done: got done pulse expected none");
        end
        run_one("after_abort", 1'b1, 8'h05, 8'h01, 16'h0005);
    endtask

    task automatic test_back_to_back;
        int cyc;
        int last_done;
        int got;
        logic [2*W-1:0] e;
        is_signed    = 1'b1;
        multiplier   = W'($urandom_range(0, 255));
        multiplicand = W'($urandom_range(0, 255));
        sb.push_back(model(1'b1, multiplier, multiplicand));
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc       = 0;
        last_done = -1;
        got       = 0;
        while (got < 5 && cyc < 200) begin
            if (done) begin
                e = sb.pop_front();
                n_checks++;
                if (product !== e) begin
                    n_fail++;
                    $display("FAIL b2b_product %0d: got %h expected %h",
                             got, product, e);
                end
                if (last_done >= 0) begin
                    n_checks++;
                    if (cyc - last_done != W + 1) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d expected %0d",
                                 cyc - last_done, W + 1);
                    end
                end
                last_done = cyc;
                got++;
                multiplier   = W'($urandom_range(0, 255));
                multiplicand = W'($urandom_range(0, 255));
                if (got < 5) begin
                    sb.push_back(model(1'b1, multiplier, multiplicand));
                end else begin
                    start = 1'b0;
                end
            end else begin
                multiplier   = W'($urandom_range(0, 255));
                multiplicand = W'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results expected 5", got);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
